// File: rtl/ps2_mouse_master_ext.sv
// PS/2 mouse master sequencer: table-driven init (reset, optional wheel knock, sample rate, enable),
// followed by 3/4-byte packet streaming with sync check, timeouts, bounded retries and atomic commit.
module ps2_mouse_master_ext #(
  parameter int         POWERUP_WAIT = 5000000,
  parameter int         RESP_TIMEOUT = 2500000,
  parameter int         PKT_TIMEOUT  = 500000,
  parameter bit         WHEEL_EN     = 1'b1,
  parameter logic [7:0] SAMPLE_RATE  = 8'd100,
  parameter int         MAX_RETRIES  = 3,
  parameter int         CNT_W        = 24
) (
  input  logic       CLK,
  input  logic       RESET,
  output logic       SEND_BYTE,
  output logic [7:0] BYTE_TO_SEND,
  input  logic       BYTE_SENT,
  output logic       READ_ENABLE,
  input  logic [7:0] BYTE_READ,
  input  logic [1:0] BYTE_ERROR_CODE,
  input  logic       BYTE_READY,
  output logic [7:0] MOUSE_STATUS,
  output logic [7:0] MOUSE_DX,
  output logic [7:0] MOUSE_DY,
  output logic [7:0] MOUSE_DZ,
  output logic       WHEEL_PRESENT,
  output logic       SEND_INTERRUPT,
  output logic       INIT_FAIL,
  output logic [3:0] RETRY_COUNT,
  output logic [3:0] CURRENT_STATE
);

  typedef enum logic [3:0] {
    ST_PWRUP     = 4'h0,
    ST_SEND      = 4'h1,
    ST_WAIT_SENT = 4'h2,
    ST_WAIT_RESP = 4'h3,
    ST_PKT_B0    = 4'h4,
    ST_PKT_B1    = 4'h5,
    ST_PKT_B2    = 4'h6,
    ST_PKT_B3    = 4'h7,
    ST_COMMIT    = 4'h8,
    ST_FAIL      = 4'hF
  } state_t;

  typedef enum logic [1:0] {K_SEND, K_EXPECT, K_ID} kind_t;

  typedef struct packed {
    kind_t      kind;
    logic [7:0] data;
  } step_t;

  localparam logic [CNT_W-1:0] PWR_LIM  = CNT_W'(POWERUP_WAIT);
  localparam logic [CNT_W-1:0] RESP_LIM = CNT_W'(RESP_TIMEOUT);
  localparam logic [CNT_W-1:0] PKT_LIM  = CNT_W'(PKT_TIMEOUT);
  localparam logic [3:0]       MAX_R    = 4'(MAX_RETRIES);
  localparam logic [4:0]       LAST_IDX = 5'd24;

  // Sends and their expected replies share one flat table; 4..18 is the wheel knock.
  function automatic step_t step_at(input logic [4:0] i);
    step_t s;
    case (i)
      5'd0:    s = '{K_SEND,   8'hFF};
      5'd1:    s = '{K_EXPECT, 8'hFA};
      5'd2:    s = '{K_EXPECT, 8'hAA};
      5'd3:    s = '{K_EXPECT, 8'h00};
      5'd4:    s = '{K_SEND,   8'hF3};
      5'd6:    s = '{K_SEND,   8'hC8};
      5'd8:    s = '{K_SEND,   8'hF3};
      5'd10:   s = '{K_SEND,   8'h64};
      5'd12:   s = '{K_SEND,   8'hF3};
      5'd14:   s = '{K_SEND,   8'h50};
      5'd16:   s = '{K_SEND,   8'hF2};
      5'd18:   s = '{K_ID,     8'h00};
      5'd19:   s = '{K_SEND,   8'hF3};
      5'd21:   s = '{K_SEND,   SAMPLE_RATE};
      5'd23:   s = '{K_SEND,   8'hF4};
      default: s = '{K_EXPECT, 8'hFA};
    endcase
    return s;
  endfunction

  function automatic logic [4:0] next_idx(input logic [4:0] i);
    return (i == 5'd3 && !WHEEL_EN) ? 5'd19 : i + 5'd1;
  endfunction

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [4:0]       idx;
  logic [7:0]       sh_status, sh_dx, sh_dy;

  step_t      cur_step, nxt_step;
  logic [4:0] nxt_idx;
  logic       rx_err, rx_ok, resp_bad, in_pkt, fail_now;
  logic [3:0] retry_inc;

  always_comb begin
    cur_step  = step_at(idx);
    nxt_idx   = next_idx(idx);
    nxt_step  = step_at(nxt_idx);
    rx_err    = BYTE_READY && (BYTE_ERROR_CODE != 2'b00);
    rx_ok     = BYTE_READY && (BYTE_ERROR_CODE == 2'b00);
    resp_bad  = 1'b0;
    if (rx_ok) begin
      if (cur_step.kind == K_ID)
        resp_bad = (BYTE_READ != 8'h03) && (BYTE_READ != 8'h00);
      else
        resp_bad = (BYTE_READ != cur_step.data);
    end
    in_pkt    = (state == ST_PKT_B0) || (state == ST_PKT_B1) ||
                (state == ST_PKT_B2) || (state == ST_PKT_B3);
    fail_now  = ((state == ST_WAIT_SENT) && (cnt >= RESP_LIM)) ||
                ((state == ST_WAIT_RESP) && (rx_err || resp_bad || (cnt >= RESP_LIM))) ||
                (in_pkt && rx_err);
    retry_inc = (RETRY_COUNT == 4'hF) ? 4'hF : RETRY_COUNT + 4'd1;
  end

  assign CURRENT_STATE = state;

  // Outputs are registered so that SEND_BYTE / SEND_INTERRUPT line up with the SEND / COMMIT states.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state          <= ST_PWRUP;
      cnt            <= '0;
      idx            <= '0;
      sh_status      <= '0;
      sh_dx          <= '0;
      sh_dy          <= '0;
      SEND_BYTE      <= 1'b0;
      BYTE_TO_SEND   <= 8'h00;
      READ_ENABLE    <= 1'b0;
      MOUSE_STATUS   <= '0;
      MOUSE_DX       <= '0;
      MOUSE_DY       <= '0;
      MOUSE_DZ       <= '0;
      WHEEL_PRESENT  <= 1'b0;
      SEND_INTERRUPT <= 1'b0;
      INIT_FAIL      <= 1'b0;
      RETRY_COUNT    <= '0;
    end else if (fail_now) begin
      RETRY_COUNT    <= retry_inc;
      SEND_BYTE      <= 1'b0;
      SEND_INTERRUPT <= 1'b0;
      READ_ENABLE    <= 1'b0;
      cnt            <= '0;
      idx            <= '0;
      if (retry_inc == MAX_R) begin
        state     <= ST_FAIL;
        INIT_FAIL <= 1'b1;
      end else begin
        state <= ST_PWRUP;
      end
    end else begin
      SEND_BYTE      <= 1'b0;
      SEND_INTERRUPT <= 1'b0;
      cnt            <= cnt + 1'b1;
      case (state)
        ST_PWRUP: begin
          if (cnt >= PWR_LIM) begin
            state        <= ST_SEND;
            SEND_BYTE    <= 1'b1;
            BYTE_TO_SEND <= cur_step.data;
            cnt          <= '0;
          end
        end
        ST_SEND: begin
          idx   <= nxt_idx;
          cnt   <= '0;
          state <= ST_WAIT_SENT;
        end
        ST_WAIT_SENT: begin
          if (BYTE_SENT) begin
            state       <= ST_WAIT_RESP;
            READ_ENABLE <= 1'b1;
            cnt         <= '0;
          end
        end
        ST_WAIT_RESP: begin
          if (rx_ok) begin
            cnt <= '0;
            if (cur_step.kind == K_ID)
              WHEEL_PRESENT <= (BYTE_READ == 8'h03);
            if (idx == LAST_IDX) begin
              state <= ST_PKT_B0;
            end else begin
              idx <= nxt_idx;
              if (nxt_step.kind == K_SEND) begin
                state        <= ST_SEND;
                SEND_BYTE    <= 1'b1;
                BYTE_TO_SEND <= nxt_step.data;
                READ_ENABLE  <= 1'b0;
              end
            end
          end
        end
        ST_PKT_B0: begin
          if (rx_ok && BYTE_READ[3]) begin
            sh_status <= BYTE_READ;
            cnt       <= '0;
            state     <= ST_PKT_B1;
          end
        end
        ST_PKT_B1: begin
          if (rx_ok) begin
            sh_dx <= BYTE_READ;
            cnt   <= '0;
            state <= ST_PKT_B2;
          end else if (cnt >= PKT_LIM) begin
            state <= ST_PKT_B0;
          end
        end
        // Without a wheel the third byte completes the packet and commits straight away.
        ST_PKT_B2: begin
          if (rx_ok) begin
            sh_dy <= BYTE_READ;
            cnt   <= '0;
            if (WHEEL_PRESENT) begin
              state <= ST_PKT_B3;
            end else begin
              MOUSE_STATUS   <= sh_status;
              MOUSE_DX       <= sh_dx;
              MOUSE_DY       <= BYTE_READ;
              MOUSE_DZ       <= 8'h00;
              SEND_INTERRUPT <= 1'b1;
              RETRY_COUNT    <= '0;
              state          <= ST_COMMIT;
            end
          end else if (cnt >= PKT_LIM) begin
            state <= ST_PKT_B0;
          end
        end
        ST_PKT_B3: begin
          if (rx_ok) begin
            MOUSE_STATUS   <= sh_status;
            MOUSE_DX       <= sh_dx;
            MOUSE_DY       <= sh_dy;
            MOUSE_DZ       <= BYTE_READ;
            SEND_INTERRUPT <= 1'b1;
            RETRY_COUNT    <= '0;
            state          <= ST_COMMIT;
          end else if (cnt >= PKT_LIM) begin
            state <= ST_PKT_B0;
          end
        end
        ST_COMMIT: begin
          cnt   <= '0;
          state <= ST_PKT_B0;
        end
        ST_FAIL: begin
          cnt <= cnt;
        end
        default: begin
          state <= ST_PWRUP;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_mouse_master_ext.sv
// Self-checking bench for ps2_mouse_master_ext: scoreboards for command bytes and committed packets,
// plus direct checks of state, retry and failure behaviour.
module tb_ps2_mouse_master_ext;

  logic       clk = 1'b0;
  logic       reset;
  logic       send_byte;
  logic [7:0] byte_to_send;
  logic       byte_sent;
  logic       read_enable;
  logic [7:0] byte_read;
  logic [1:0] byte_error_code;
  logic       byte_ready;
  logic [7:0] mouse_status, mouse_dx, mouse_dy, mouse_dz;
  logic       wheel_present, send_interrupt, init_fail;
  logic [3:0] retry_count, current_state;

  int assert_count = 0;
  int fail_count   = 0;
  int send_count   = 0;
  int int_count    = 0;
  int exp_sends    = 0;
  bit got;

  logic [7:0]  send_q[$];
  logic [31:0] pkt_q[$];

  logic [7:0] wheel_sends [11] = '{8'hFF, 8'hF3, 8'hC8, 8'hF3, 8'h64, 8'hF3,
                                   8'h50, 8'hF2, 8'hF3, 8'h64, 8'hF4};

  always #5 clk = ~clk;

  ps2_mouse_master_ext #(
    .POWERUP_WAIT (16),
    .RESP_TIMEOUT (200),
    .PKT_TIMEOUT  (50),
    .WHEEL_EN     (1'b1),
    .SAMPLE_RATE  (8'd100),
    .MAX_RETRIES  (3),
    .CNT_W        (24)
  ) dut (
    .CLK             (clk),
    .RESET           (reset),
    .SEND_BYTE       (send_byte),
    .BYTE_TO_SEND    (byte_to_send),
    .BYTE_SENT       (byte_sent),
    .READ_ENABLE     (read_enable),
    .BYTE_READ       (byte_read),
    .BYTE_ERROR_CODE (byte_error_code),
    .BYTE_READY      (byte_ready),
    .MOUSE_STATUS    (mouse_status),
    .MOUSE_DX        (mouse_dx),
    .MOUSE_DY        (mouse_dy),
    .MOUSE_DZ        (mouse_dz),
    .WHEEL_PRESENT   (wheel_present),
    .SEND_INTERRUPT  (send_interrupt),
    .INIT_FAIL       (init_fail),
    .RETRY_COUNT     (retry_count),
    .CURRENT_STATE   (current_state)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    assert_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Every command byte the DUT issues must be the next one queued by the bench.
  always @(negedge clk) begin
    if (reset && send_byte) begin
      send_count++;
      checkOutput("send_expected", 32'(send_q.size() > 0), 32'h1);
      if (send_q.size() > 0)
        checkOutput("send_byte", 32'(byte_to_send), 32'(send_q.pop_front()));
    end
  end

  always @(negedge clk) begin
    if (reset && send_interrupt) begin
      int_count++;
      checkOutput("commit_state", 32'(current_state), 32'h8);
      checkOutput("commit_retry", 32'(retry_count), 32'h0);
      checkOutput("int_expected", 32'(pkt_q.size() > 0), 32'h1);
      if (pkt_q.size() > 0)
        checkOutput("commit_pkt", {mouse_status, mouse_dx, mouse_dy, mouse_dz}, pkt_q.pop_front());
    end
  end

  task automatic applyStimulus(input logic [7:0] b, input logic [1:0] err);
    @(negedge clk);
    byte_read       = b;
    byte_error_code = err;
    byte_ready      = 1'b1;
    @(negedge clk);
    byte_ready      = 1'b0;
    byte_error_code = 2'b00;
  endtask

  task automatic sentPulse();
    @(negedge clk);
    byte_sent = 1'b1;
    @(negedge clk);
    byte_sent = 1'b0;
  endtask

  task automatic waitForSend(input int limit, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (send_byte) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Plays the mouse side of the init; a bad ID stops after the F2 exchange.
  task automatic runInit(input logic [7:0] id);
    int n;
    bit seen;
    n = (id == 8'h03 || id == 8'h00) ? 11 : 8;
    for (int i = 0; i < n; i++) begin
      send_q.push_back(wheel_sends[i]);
      exp_sends++;
    end
    for (int i = 0; i < n; i++) begin
      waitForSend(400, seen);
      checkOutput("init_send_seen", 32'(seen), 32'h1);
      if (!seen) return;
      sentPulse();
      applyStimulus(8'hFA, 2'b00);
      if (wheel_sends[i] == 8'hFF) begin
        applyStimulus(8'hAA, 2'b00);
        applyStimulus(8'h00, 2'b00);
      end
      if (wheel_sends[i] == 8'hF2)
        applyStimulus(id, 2'b00);
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: observed no end of test, expected $finish within 1 ms");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset           = 1'b0;
    byte_sent       = 1'b0;
    byte_read       = 8'h00;
    byte_error_code = 2'b00;
    byte_ready      = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_state", 32'(current_state), 32'h0);
    checkOutput("rst_ctrl", 32'({send_byte, read_enable, send_interrupt, init_fail, wheel_present, retry_count}), 32'h0);
    checkOutput("rst_data", {mouse_status, mouse_dx, mouse_dy, mouse_dz}, 32'h0);
    checkOutput("rst_tx", 32'(byte_to_send), 32'h0);
    reset = 1'b1;

    runInit(8'h03);
    checkOutput("init_sends", 32'(send_count), 32'd11);
    checkOutput("wheel_present", 32'(wheel_present), 32'h1);
    checkOutput("init_done_state", 32'(current_state), 32'h4);
    checkOutput("stream_read_en", 32'(read_enable), 32'h1);

    pkt_q.push_back(32'h0805FBFF);
    applyStimulus(8'h08, 2'b00);
    applyStimulus(8'h05, 2'b00);
    applyStimulus(8'hFB, 2'b00);
    checkOutput("b3_state", 32'(current_state), 32'h7);
    checkOutput("no_partial", {mouse_status, mouse_dx, mouse_dy, mouse_dz}, 32'h0);
    applyStimulus(8'hFF, 2'b00);
    @(negedge clk);
    checkOutput("wheel_int_count", 32'(int_count), 32'd1);
    checkOutput("after_commit_state", 32'(current_state), 32'h4);

    applyStimulus(8'h00, 2'b00);
    checkOutput("resync1", 32'(current_state), 32'h4);
    applyStimulus(8'h00, 2'b00);
    checkOutput("resync2", 32'(current_state), 32'h4);
    applyStimulus(8'h08, 2'b00);
    checkOutput("sync_found", 32'(current_state), 32'h5);
    applyStimulus(8'h01, 2'b00);
    repeat (60) @(negedge clk);
    checkOutput("pkt_timeout_state", 32'(current_state), 32'h4);
    checkOutput("pkt_timeout_int", 32'(int_count), 32'd1);
    checkOutput("pkt_timeout_data", {mouse_status, mouse_dx, mouse_dy, mouse_dz}, 32'h0805FBFF);

    applyStimulus(8'h08, 2'b00);
    applyStimulus(8'h55, 2'b01);
    checkOutput("stream_err_state", 32'(current_state), 32'h0);
    checkOutput("stream_err_retry", 32'(retry_count), 32'h1);
    checkOutput("stream_err_re", 32'(read_enable), 32'h0);

    runInit(8'h00);
    checkOutput("id00_wheel", 32'(wheel_present), 32'h0);
    checkOutput("id00_retry_kept", 32'(retry_count), 32'h1);
    checkOutput("id00_state", 32'(current_state), 32'h4);
    pkt_q.push_back(32'h09010200);
    applyStimulus(8'h09, 2'b00);
    applyStimulus(8'h01, 2'b00);
    applyStimulus(8'h02, 2'b00);
    @(negedge clk);
    checkOutput("3byte_int_count", 32'(int_count), 32'd2);
    checkOutput("3byte_retry_clear", 32'(retry_count), 32'h0);

    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    runInit(8'h07);
    checkOutput("bad_id_state", 32'(current_state), 32'h0);
    checkOutput("bad_id_retry", 32'(retry_count), 32'h1);
    checkOutput("bad_id_wheel", 32'(wheel_present), 32'h0);

    send_q.push_back(8'hFF);
    exp_sends++;
    waitForSend(100, got);
    checkOutput("retry_send_seen", 32'(got), 32'h1);
    sentPulse();
    applyStimulus(8'hFA, 2'b00);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("midreset_state", 32'(current_state), 32'h0);
    checkOutput("midreset_ctrl", 32'({send_byte, read_enable, send_interrupt, init_fail, wheel_present, retry_count}), 32'h0);
    checkOutput("midreset_tx", 32'(byte_to_send), 32'h0);

    for (int i = 0; i < 3; i++) begin
      send_q.push_back(8'hFF);
      exp_sends++;
    end
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      waitForSend(400, got);
      checkOutput("noanswer_send_seen", 32'(got), 32'h1);
      checkOutput("noanswer_retry", 32'(retry_count), 32'(k));
      @(negedge clk);
    end
    for (int i = 0; i < 400; i++) begin
      if (current_state == 4'hF) break;
      @(negedge clk);
    end
    checkOutput("fail_state", 32'(current_state), 32'hF);
    checkOutput("fail_retry", 32'(retry_count), 32'h3);
    checkOutput("fail_flag", 32'(init_fail), 32'h1);
    checkOutput("fail_read_en", 32'(read_enable), 32'h0);
    repeat (300) @(negedge clk);
    checkOutput("total_sends", 32'(send_count), 32'(exp_sends));
    checkOutput("send_q_drained", 32'(send_q.size()), 32'h0);
    checkOutput("pkt_q_drained", 32'(pkt_q.size()), 32'h0);
    checkOutput("fail_parked", 32'(current_state), 32'hF);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
